// File: rtl/random_resized_crop.sv
// random_resized_crop: buffers one frame, then streams a centred crop rescaled
// back to full size by nearest-neighbour sampling.
module random_resized_crop #(
  parameter int IMG_DIM = 28,
  parameter int PIX_W   = 8,
  parameter int CROP_0  = 28,
  parameter int CROP_1  = 24,
  parameter int CROP_2  = 20,
  parameter int CROP_3  = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic [1:0]       scale,
  output logic             lfsr_enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_last,
  output logic             busy
);
  localparam int N  = IMG_DIM * IMG_DIM;
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(IMG_DIM);
  localparam int SW = $clog2(2 * IMG_DIM);
  typedef enum logic {LOAD, EMIT} state_t;
  state_t state, state_n;
  logic [PIX_W-1:0] mem [N];
  logic [AW-1:0] count, addr;
  logic [1:0] sel;
  logic [CW-1:0] x, y;
  logic [SW-1:0] ax, ay, ix, iy, crop, off, ax_sum, ay_sum;
  logic gen_done, in_fire, in_end, advance, step, out_done, x_end, y_end, ax_wrap, ay_wrap;
  always_comb begin
    in_ready = state == LOAD;
    in_fire = in_valid && in_ready;
    in_end = in_fire && count == AW'(N - 1);
    lfsr_enable = in_end && !reset;
    busy = state == EMIT || count != '0;
    advance = !out_valid || out_ready;
    step = state == EMIT && advance && !gen_done;
    out_done = out_valid && out_ready && out_last;
    state_n = in_end ? EMIT : out_done ? LOAD : state;
    crop = sel == 2'd0 ? SW'(CROP_0) : sel == 2'd1 ? SW'(CROP_1) : sel == 2'd2 ? SW'(CROP_2) : SW'(CROP_3);
    off = (SW'(IMG_DIM) - crop) >> 1;
    ax_sum = ax + crop;
    ay_sum = ay + crop;
    ax_wrap = ax_sum >= SW'(IMG_DIM);
    ay_wrap = ay_sum >= SW'(IMG_DIM);
    x_end = x == CW'(IMG_DIM - 1);
    y_end = y == CW'(IMG_DIM - 1);
    addr = AW'(off + iy) * AW'(IMG_DIM) + AW'(off + ix);
  end
  always_ff @(posedge clk) begin
    if (in_fire) mem[count] <= in_pixel;
  end
  // out_pixel is the read register itself; it only loads when the slot frees, so it doubles as the hold register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
      count <= '0;
      sel <= '0;
      {x, y} <= '0;
      {ax, ay, ix, iy} <= '0;
      gen_done <= 1'b0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_pixel <= '0;
    end else begin
      state <= state_n;
      if (in_fire) count <= in_end ? '0 : count + 1'b1;
      if (in_end) sel <= scale;
      if (state == EMIT && advance) begin
        out_valid <= !gen_done;
        out_last <= !gen_done && x_end && y_end;
        if (!gen_done) out_pixel <= mem[addr];
      end
      if (step) begin
        x <= x_end ? '0 : x + 1'b1;
        ax <= x_end ? '0 : ax_wrap ? ax_sum - SW'(IMG_DIM) : ax_sum;
        ix <= x_end ? '0 : ix + SW'(ax_wrap);
        if (x_end) begin
          y <= y + 1'b1;
          ay <= ay_wrap ? ay_sum - SW'(IMG_DIM) : ay_sum;
          iy <= iy + SW'(ay_wrap);
          gen_done <= y_end;
        end
      end
      if (out_done) begin
        {x, y} <= '0;
        {ax, ay, ix, iy} <= '0;
        gen_done <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_random_resized_crop.sv
// tb_random_resized_crop: directed frames against a division-based crop model.
module tb_random_resized_crop;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, lfsr_enable, out_valid, out_ready, out_last, busy;
  logic [7:0] in_pixel, out_pixel;
  logic [1:0] scale;
  int checks = 0, errors = 0;
  int got [784];
  typedef struct {int sc; int x; int y; int exp;} vec_t;
  vec_t vecs [11];

  always #5 clk = ~clk;

  random_resized_crop dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .scale(scale), .lfsr_enable(lfsr_enable), .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_last(out_last), .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int model(input int sc, input int idx);
    int c, off, sx, sy;
    c = sc == 0 ? 28 : sc == 1 ? 24 : sc == 2 ? 20 : 14;
    off = (28 - c) / 2;
    sx = off + (idx % 28) * c / 28;
    sy = off + (idx / 28) * c / 28;
    return (sy * 28 + sx) % 256;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1 chk("lfsr_in_reset", int'(lfsr_enable), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_pixel", int'(out_pixel), 0);
    chk("rst_lfsr", int'(lfsr_enable), 0);
    chk("rst_busy", int'(busy), 0);
  endtask

  task automatic load_frame(input int early, input int sc, input int abort_at, output int pulses, output int at);
    pulses = 0; at = -1;
    for (int p = 0; p < 784; p++) begin
      if (p == abort_at) return;
      @(negedge clk);
      in_valid = 1'b1;
      in_pixel = p[7:0];
      scale = 2'(p < 392 ? early : sc);
      #1;
      if (lfsr_enable) begin pulses++; at = p; end
      if (p == 1) begin
        chk("busy_load", int'(busy), 1);
        chk("in_ready_load", int'(in_ready), 1);
      end
    end
  endtask

  task automatic read_frame(input int sc, input bit toggle, input int abort_at);
    int idx = 0, cyc = 0, first = -1, pp = 0, pl = 0, bad_lfsr = 0, bad_ready = 0;
    bit stall = 1'b0;
    while (idx < 784 && idx != abort_at) begin
      @(negedge clk);
      in_valid = toggle;
      in_pixel = 8'hAA;
      out_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      cyc++;
      if (lfsr_enable) bad_lfsr++;
      if (in_ready) bad_ready++;
      if (first < 0 && out_valid) first = cyc;
      if (stall) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_pixel", int'(out_pixel), pp);
        chk("hold_last", int'(out_last), pl);
      end
      if (out_valid && out_ready) begin
        got[idx] = int'(out_pixel);
        chk("pixel", int'(out_pixel), model(sc, idx));
        chk("last", int'(out_last), int'(idx == 783));
        idx++;
      end
      stall = out_valid && !out_ready;
      pp = int'(out_pixel);
      pl = int'(out_last);
      if (cyc > 4000) begin
        chk("timeout_pixels", idx, 784);
        break;
      end
    end
    chk("first_valid_latency_ok", int'(first inside {[1:2]}), 1);
    chk("no_lfsr_in_emit", bad_lfsr, 0);
    chk("in_ready_low_emit", bad_ready, 0);
    if (idx == 784) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("in_ready_after_last", int'(in_ready), 1);
      chk("busy_after_last", int'(busy), 0);
    end
  endtask

  task automatic frame(input int early, input int sc, input bit toggle);
    int pulses, at;
    load_frame(early, sc, -1, pulses, at);
    chk("lfsr_pulses", pulses, 1);
    chk("lfsr_at", at, 783);
    read_frame(sc, toggle, -1);
  endtask

  task automatic check_table(input int sc);
    for (int i = 0; i < 11; i++)
      if (vecs[i].sc == sc) chk($sformatf("vec%0d", i), got[vecs[i].y * 28 + vecs[i].x], vecs[i].exp);
  endtask

  initial begin
    int pulses, at;
    vecs[0] = '{0, 5, 3, 89};
    vecs[1] = '{0, 27, 27, 15};
    vecs[2] = '{3, 0, 0, 203};
    vecs[3] = '{3, 1, 0, 203};
    vecs[4] = '{3, 2, 0, 204};
    vecs[5] = '{3, 0, 1, 203};
    vecs[6] = '{3, 27, 27, 68};
    vecs[7] = '{1, 0, 0, 58};
    vecs[8] = '{1, 27, 27, 213};
    vecs[9] = '{2, 0, 0, 116};
    vecs[10] = '{2, 27, 27, 155};
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pixel = '0; scale = '0;
    do_reset();
    frame(0, 0, 1'b0); check_table(0);
    frame(3, 3, 1'b0); check_table(3);
    frame(1, 1, 1'b0); check_table(1);
    frame(2, 2, 1'b1); check_table(2);
    load_frame(2, 2, 400, pulses, at);
    chk("abort_load_lfsr", pulses, 0);
    do_reset();
    load_frame(2, 2, -1, pulses, at);
    chk("pre_abort_lfsr", pulses, 1);
    read_frame(2, 1'b0, 300);
    do_reset();
    frame(1, 1, 1'b0); check_table(1);
    frame(3, 0, 1'b0); check_table(0);
    frame(0, 3, 1'b0); check_table(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
